// File: rtl/um_pktin_arb_if.sv
// Bus bundle between the two MAC-side ingress ports, the merger and um's pktin side.
// Handshake: every *_wr strobe is a single-cycle qualifier. Words and descriptors carry
// no per-word backpressure. pktin_ready is a per-packet credit, sampled only when a packet starts.
interface um_pktin_arb_if #(
    parameter int AW = 8
);
    logic [133:0] port0_data;
    logic         port0_data_wr;
    logic         port0_valid;
    logic         port0_valid_wr;
    logic [AW:0]  port0_usedw;
    logic [31:0]  port0_drop_cnt;

    logic [133:0] port1_data;
    logic         port1_data_wr;
    logic         port1_valid;
    logic         port1_valid_wr;
    logic [AW:0]  port1_usedw;
    logic [31:0]  port1_drop_cnt;

    logic [133:0] pktin_data;
    logic         pktin_data_wr;
    logic         pktin_valid;
    logic         pktin_valid_wr;
    logic         pktin_ready;

    modport slave (
        input  port0_data, port0_data_wr, port0_valid, port0_valid_wr,
        output port0_usedw, port0_drop_cnt,
        input  port1_data, port1_data_wr, port1_valid, port1_valid_wr,
        output port1_usedw, port1_drop_cnt,
        output pktin_data, pktin_data_wr, pktin_valid, pktin_valid_wr,
        input  pktin_ready
    );

    modport master (
        output port0_data, port0_data_wr, port0_valid, port0_valid_wr,
        input  port0_usedw, port0_drop_cnt,
        output port1_data, port1_data_wr, port1_valid, port1_valid_wr,
        input  port1_usedw, port1_drop_cnt,
        input  pktin_data, pktin_data_wr, pktin_valid, pktin_valid_wr,
        output pktin_ready
    );
endinterface

// File: rtl/um_pktin_arb.sv
// Two-port store-and-forward ingress merger feeding um: per-port data/descriptor FIFOs,
// bad/overflowed packets discarded on the write side, packet-granularity round-robin read.
module um_pktin_arb #(
    parameter int AW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    um_pktin_arb_if.slave bus,
    output logic [1:0]    dbg_state
);
    localparam int DEPTH  = 1 << AW;
    localparam int DDEPTH = 1 << PW;
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(DEPTH);
    localparam logic [PW:0]   DESC_FULL = (PW + 1)'(DDEPTH);
    localparam logic [AW:0]   W_ONE     = (AW + 1)'(1);
    localparam logic [PW:0]   P_ONE     = (PW + 1)'(1);
    localparam logic [AW-1:0] A_ONE     = AW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, SEND = 2'd2, DESC = 2'd3} state_t;
    state_t state, state_next;

    logic [133:0]  in_data     [2];
    logic          in_data_wr  [2];
    logic          in_valid    [2];
    logic          in_valid_wr [2];
    logic [AW:0]   usedw       [2];
    logic [31:0]   drop_cnt    [2];
    logic          has_pkt     [2];
    logic [AW-1:0] rd_base     [2];
    logic [AW:0]   head_len    [2];
    logic [133:0]  rd_word     [2];
    logic          pop         [2];

    logic          grant, last_grant, gnt_sel, start_rd, last_word;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   sent;
    logic [133:0]  ram_q;
    logic          data_wr_q, valid_wr_q;

    assign in_data[0]     = bus.port0_data;
    assign in_data_wr[0]  = bus.port0_data_wr;
    assign in_valid[0]    = bus.port0_valid;
    assign in_valid_wr[0] = bus.port0_valid_wr;
    assign in_data[1]     = bus.port1_data;
    assign in_data_wr[1]  = bus.port1_data_wr;
    assign in_valid[1]    = bus.port1_valid;
    assign in_valid_wr[1] = bus.port1_valid_wr;

    assign bus.port0_usedw    = usedw[0];
    assign bus.port0_drop_cnt = drop_cnt[0];
    assign bus.port1_usedw    = usedw[1];
    assign bus.port1_drop_cnt = drop_cnt[1];

    assign bus.pktin_data     = ram_q;
    assign bus.pktin_data_wr  = data_wr_q;
    assign bus.pktin_valid    = valid_wr_q;
    assign bus.pktin_valid_wr = valid_wr_q;
    assign dbg_state          = state;

    for (genvar i = 0; i < 2; i++) begin : g_port
        logic [133:0] mem  [DEPTH];
        logic [AW:0]  dmem [DDEPTH];
        logic [AW:0]  wr_ptr, cmt_ptr, rd_ptr, start, base;
        logic [PW:0]  dwr, drd, pkt_cnt;
        logic [31:0]  drops;
        logic         pkt_open, ovf, is_head, fifo_full, desc_full, wr_en, commit;

        // A head on an open packet restarts from the last committed word.
        always_comb begin
            is_head   = in_data[i][133:132] == 2'b01;
            base      = (is_head && pkt_open) ? cmt_ptr : wr_ptr;
            fifo_full = (base - rd_ptr) == FIFO_FULL;
            desc_full = (dwr - drd) == DESC_FULL;
            wr_en     = in_data_wr[i] && (is_head || pkt_open) && !fifo_full;
            commit    = !in_data_wr[i] && in_valid_wr[i] && pkt_open && in_valid[i] && !ovf;
        end

        always_ff @(posedge clk) begin
            if (wr_en)  mem[base[AW-1:0]] <= in_data[i];
            if (commit) dmem[dwr[PW-1:0]] <= wr_ptr - start;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr   <= '0;
                cmt_ptr  <= '0;
                rd_ptr   <= '0;
                start    <= '0;
                dwr      <= '0;
                drd      <= '0;
                pkt_cnt  <= '0;
                drops    <= '0;
                pkt_open <= 1'b0;
                ovf      <= 1'b0;
            end else begin
                if (in_data_wr[i]) begin
                    if (is_head) begin
                        pkt_open <= 1'b1;
                        start    <= base;
                        ovf      <= fifo_full || desc_full;
                        wr_ptr   <= fifo_full ? base : base + W_ONE;
                        if (pkt_open && drops != '1) drops <= drops + 32'd1;
                    end else if (pkt_open) begin
                        ovf <= ovf || fifo_full;
                        if (!fifo_full) wr_ptr <= wr_ptr + W_ONE;
                    end
                end else if (in_valid_wr[i] && pkt_open) begin
                    pkt_open <= 1'b0;
                    if (commit) begin
                        cmt_ptr <= wr_ptr;
                        dwr     <= dwr + P_ONE;
                    end else begin
                        wr_ptr <= cmt_ptr;
                        if (drops != '1) drops <= drops + 32'd1;
                    end
                end
                if (pop[i]) begin
                    drd    <= drd + P_ONE;
                    rd_ptr <= rd_ptr + head_len[i];
                end
                case ({commit, pop[i]})
                    2'b10:   pkt_cnt <= pkt_cnt + P_ONE;
                    2'b01:   pkt_cnt <= pkt_cnt - P_ONE;
                    default: pkt_cnt <= pkt_cnt;
                endcase
            end
        end

        assign pop[i]      = (state == DESC) && (grant == 1'(i));
        assign usedw[i]    = wr_ptr - rd_ptr;
        assign drop_cnt[i] = drops;
        assign has_pkt[i]  = pkt_cnt != '0;
        assign rd_base[i]  = rd_ptr[AW-1:0];
        assign head_len[i] = dmem[drd[PW-1:0]];
        assign rd_word[i]  = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Descriptor length bounds the read in case a committed packet lacks a tail word.
    always_comb begin
        state_next = state;
        start_rd   = 1'b0;
        last_word  = (ram_q[133:132] == 2'b10) || (sent == head_len[grant]);
        gnt_sel    = (has_pkt[0] && has_pkt[1]) ? ~last_grant : has_pkt[1];
        case (state)
            IDLE: if (bus.pktin_ready && (has_pkt[0] || has_pkt[1])) begin
                start_rd   = 1'b1;
                state_next = RD;
            end
            RD:      state_next = SEND;
            SEND:    if (last_word) state_next = DESC;
            DESC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            rd_addr    <= '0;
            sent       <= '0;
            ram_q      <= '0;
            data_wr_q  <= 1'b0;
            valid_wr_q <= 1'b0;
        end else begin
            data_wr_q  <= 1'b0;
            valid_wr_q <= 1'b0;
            case (state)
                IDLE: if (start_rd) begin
                    grant   <= gnt_sel;
                    rd_addr <= rd_base[gnt_sel];
                end
                RD: begin
                    ram_q     <= rd_word[grant];
                    rd_addr   <= rd_addr + A_ONE;
                    sent      <= W_ONE;
                    data_wr_q <= 1'b1;
                end
                SEND: if (last_word) begin
                    valid_wr_q <= 1'b1;
                end else begin
                    ram_q     <= rd_word[grant];
                    rd_addr   <= rd_addr + A_ONE;
                    sent      <= sent + W_ONE;
                    data_wr_q <= 1'b1;
                end
                DESC:    last_grant <= grant;
                default: ;
            endcase
        end
    end
endmodule
